// File: rtl/trojan_payload_leak_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trojan_payload_leak_pkg
// Description : Shared FSM encodings, default preamble and sizing helper for
//               the trojan trigger and payload stages.
// Revision    : 1.0 - initial release
// ============================================================================
package trojan_payload_leak_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [7:0] PREAMBLE_DEF = 8'hA5;
  localparam int         PRE_BITS     = 8;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : trojan_payload_leak_pkg
`default_nettype wire

// File: rtl/trojan_payload_leak_if.sv
`default_nettype none
// ============================================================================
// Module      : trojan_payload_leak_if
// Description : Bundle of trigger/key inputs and serial leak outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface trojan_payload_leak_if #(
  parameter int KEY_W = 64
);
  logic             Tj_Trig;
  logic [KEY_W-1:0] key;
  logic             leak_out;
  logic             leak_valid;
  logic             busy;
  logic             done;

  modport master (
    output Tj_Trig, key,
    input  leak_out, leak_valid, busy, done
  );

  modport slave (
    input  Tj_Trig, key,
    output leak_out, leak_valid, busy, done
  );
endinterface : trojan_payload_leak_if
`default_nettype wire

// File: rtl/trojan_payload_leak.sv
`default_nettype none
// ============================================================================
// Module      : trojan_payload_leak
// Description : On a trigger rising edge, serializes a preamble followed by a
//               captured key MSB first, each bit held BIT_CYCLES clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module trojan_payload_leak
  import trojan_payload_leak_pkg::*;
#(
  parameter int         KEY_W      = 64,
  parameter int         BIT_CYCLES = 4,
  parameter logic [7:0] PREAMBLE   = PREAMBLE_DEF
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             Tj_Trig,
  input  wire logic [KEY_W-1:0] key,
  output logic                  leak_out,
  output logic                  leak_valid,
  output logic                  busy,
  output logic                  done
);

  // Index counter is shared by preamble and key phases, so it must reach both.
  localparam int IDX_W = cnt_width((KEY_W > PRE_BITS) ? KEY_W : PRE_BITS);
  localparam int PER_W = cnt_width(BIT_CYCLES);

  localparam logic [IDX_W-1:0] PRE_LAST = IDX_W'(PRE_BITS - 1);
  localparam logic [IDX_W-1:0] KEY_LAST = IDX_W'(KEY_W - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [PER_W-1:0] PER_ONE  = PER_W'(1);

  state_e           state_q;
  logic             trig_q;
  logic [KEY_W-1:0] shadow_q;
  logic [7:0]       pre_q;
  logic [IDX_W-1:0] bit_idx_q;
  logic [PER_W-1:0] period_q;
  logic             leak_out_q;
  logic             leak_valid_q;
  logic             busy_q;
  logic             done_q;

  logic w_trig_rise;
  logic w_period_end;

  assign w_trig_rise  = Tj_Trig & ~trig_q;
  assign w_period_end = (period_q == PER_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      trig_q       <= 1'b1;
      shadow_q     <= '0;
      pre_q        <= '0;
      bit_idx_q    <= '0;
      period_q     <= '0;
      leak_out_q   <= 1'b0;
      leak_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      trig_q <= Tj_Trig;

      case (state_q)
        ST_IDLE: begin
          if (w_trig_rise) begin
            state_q      <= ST_PRE;
            shadow_q     <= key;
            pre_q        <= PREAMBLE;
            bit_idx_q    <= '0;
            period_q     <= '0;
            leak_out_q   <= PREAMBLE[7];
            leak_valid_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end

        // pre_q is shifted so bit 7 always holds the bit now on the line.
        ST_PRE: begin
          if (w_period_end) begin
            period_q <= '0;
            if (bit_idx_q == PRE_LAST) begin
              state_q    <= ST_DATA;
              bit_idx_q  <= '0;
              leak_out_q <= shadow_q[KEY_W-1];
            end else begin
              bit_idx_q  <= bit_idx_q + IDX_ONE;
              pre_q      <= {pre_q[6:0], 1'b0};
              leak_out_q <= pre_q[6];
            end
          end else begin
            period_q <= period_q + PER_ONE;
          end
        end

        ST_DATA: begin
          if (w_period_end) begin
            period_q <= '0;
            if (bit_idx_q == KEY_LAST) begin
              state_q      <= ST_DONE;
              bit_idx_q    <= '0;
              leak_out_q   <= 1'b0;
              leak_valid_q <= 1'b0;
              done_q       <= 1'b1;
            end else begin
              bit_idx_q  <= bit_idx_q + IDX_ONE;
              shadow_q   <= {shadow_q[KEY_W-2:0], 1'b0};
              leak_out_q <= shadow_q[KEY_W-2];
            end
          end else begin
            period_q <= period_q + PER_ONE;
          end
        end

        // Trigger edges seen here are absorbed by trig_q and never queued.
        ST_DONE: begin
          state_q  <= ST_IDLE;
          done_q   <= 1'b0;
          busy_q   <= 1'b0;
          period_q <= '0;
        end

        default: begin
          state_q      <= ST_IDLE;
          leak_out_q   <= 1'b0;
          leak_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          done_q       <= 1'b0;
        end
      endcase
    end
  end

  assign leak_out   = leak_out_q;
  assign leak_valid = leak_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule : trojan_payload_leak
`default_nettype wire

// File: tb/tb_trojan_payload_leak.sv
`default_nettype none
// ============================================================================
// Module      : tb_trojan_payload_leak
// Description : Scoreboard bench: 4-cycle and 1-cycle bit period instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trojan_payload_leak;
  import trojan_payload_leak_pkg::*;

  localparam int KW = 64;
  localparam logic [KW-1:0] KEY1 = 64'h0123456789ABCDEF;
  localparam logic [KW-1:0] KEY2 = 64'h8000000000000001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  trojan_payload_leak_if #(.KEY_W(KW)) ifa ();
  trojan_payload_leak_if #(.KEY_W(KW)) ifb ();

  trojan_payload_leak #(.KEY_W(KW), .BIT_CYCLES(4), .PREAMBLE(8'hA5)) dut_a (
    .clk(clk), .rst(rst), .Tj_Trig(ifa.Tj_Trig), .key(ifa.key),
    .leak_out(ifa.leak_out), .leak_valid(ifa.leak_valid),
    .busy(ifa.busy), .done(ifa.done)
  );

  trojan_payload_leak #(.KEY_W(KW), .BIT_CYCLES(1), .PREAMBLE(8'hA5)) dut_b (
    .clk(clk), .rst(rst), .Tj_Trig(ifb.Tj_Trig), .key(ifb.key),
    .leak_out(ifb.leak_out), .leak_valid(ifb.leak_valid),
    .busy(ifb.busy), .done(ifb.done)
  );

  int checks   = 0;
  int failures = 0;
  bit expq_a[$];
  bit expq_b[$];
  int valid_a = 0, done_a = 0, valid_b = 0, done_b = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected serial stream: preamble MSB first, then key MSB first.
  task automatic push_frame(input int which, input logic [KW-1:0] k, input int bc);
    logic [7:0] p;
    p = PREAMBLE_DEF;
    for (int i = 7; i >= 0; i--)
      for (int c = 0; c < bc; c++)
        if (which == 0) expq_a.push_back(p[i]); else expq_b.push_back(p[i]);
    for (int i = KW - 1; i >= 0; i--)
      for (int c = 0; c < bc; c++)
        if (which == 0) expq_a.push_back(k[i]); else expq_b.push_back(k[i]);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitors: pop one expected bit per valid cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (ifa.leak_valid) begin
        valid_a++;
        if (expq_a.size() == 0) check("a_unexpected_valid", ifa.leak_valid, 0);
        else check("a_leak_bit", ifa.leak_out, expq_a.pop_front());
      end else begin
        check("a_idle_leak_zero", ifa.leak_out, 0);
      end
      if (ifa.done) done_a++;
      if (ifb.leak_valid) begin
        valid_b++;
        if (expq_b.size() == 0) check("b_unexpected_valid", ifb.leak_valid, 0);
        else check("b_leak_bit", ifb.leak_out, expq_b.pop_front());
      end else begin
        check("b_idle_leak_zero", ifb.leak_out, 0);
      end
      if (ifb.done) done_b++;
    end
  end

  task automatic wait_done_a(input string name);
    int n;
    n = 0;
    while (!ifa.done && n < 400) begin
      tick(1);
      n++;
    end
    check(name, (n < 400), 1);
  endtask

  task automatic frame_a_checks(input string tag);
    tick(3);
    check({tag, "_valid_cycles"}, valid_a, 288);
    check({tag, "_done_pulses"}, done_a, 1);
    check({tag, "_queue_empty"}, expq_a.size(), 0);
    check({tag, "_busy_low"}, ifa.busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    ifa.Tj_Trig = 1'b1; ifa.key = '0;
    ifb.Tj_Trig = 1'b0; ifb.key = '0;
    #12;
    check("rst_outputs_a", {ifa.leak_out, ifa.leak_valid, ifa.busy, ifa.done}, 0);
    check("rst_outputs_b", {ifb.leak_out, ifb.leak_valid, ifb.busy, ifb.done}, 0);
    @(posedge clk); #2;
    rst = 1'b0;

    // Trigger held high through reset release must not start a frame.
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("trig_high_busy", ifa.busy, 0);
      check("trig_high_valid", ifa.leak_valid, 0);
    end
    ifa.Tj_Trig = 1'b0;
    tick(3);

    // Basic frame.
    valid_a = 0; done_a = 0;
    push_frame(0, KEY1, 4);
    ifa.key = KEY1;
    ifa.Tj_Trig = 1'b1;
    tick(1);
    check("first_bit_latency_valid", ifa.leak_valid, 1);
    check("first_bit_latency_bit", ifa.leak_out, 1);
    check("busy_in_frame", ifa.busy, 1);
    tick(1);
    ifa.Tj_Trig = 1'b0;
    wait_done_a("basic_done_timeout");
    frame_a_checks("basic");

    // Key change at cycle 40 and retrigger at cycle 50.
    valid_a = 0; done_a = 0;
    push_frame(0, KEY1, 4);
    ifa.Tj_Trig = 1'b1;
    tick(2);
    ifa.Tj_Trig = 1'b0;
    tick(38);
    ifa.key = 64'hFFFFFFFFFFFFFFFF;
    tick(10);
    ifa.Tj_Trig = 1'b1;
    tick(2);
    ifa.Tj_Trig = 1'b0;
    wait_done_a("retrig_done_timeout");
    frame_a_checks("retrig");
    tick(300);
    check("no_second_frame_valid", valid_a, 288);
    check("no_second_frame_done", done_a, 1);

    // Asynchronous reset 100 cycles into a frame.
    ifa.key = KEY1;
    valid_a = 0; done_a = 0;
    push_frame(0, KEY1, 4);
    ifa.Tj_Trig = 1'b1;
    tick(2);
    ifa.Tj_Trig = 1'b0;
    tick(98);
    #2 rst = 1'b1;
    #1;
    check("async_rst_outputs", {ifa.leak_out, ifa.leak_valid, ifa.busy, ifa.done}, 0);
    expq_a.delete();
    tick(4);
    @(posedge clk); #2;
    rst = 1'b0;
    tick(10);
    check("abort_no_done", done_a, 0);
    check("abort_idle_busy", ifa.busy, 0);
    valid_a = 0; done_a = 0;
    push_frame(0, KEY1, 4);
    ifa.Tj_Trig = 1'b1;
    tick(2);
    ifa.Tj_Trig = 1'b0;
    wait_done_a("post_rst_done_timeout");
    frame_a_checks("post_rst");

    // Single-cycle bit period instance.
    valid_b = 0; done_b = 0;
    push_frame(1, KEY2, 1);
    ifb.key = KEY2;
    ifb.Tj_Trig = 1'b1;
    tick(2);
    ifb.Tj_Trig = 1'b0;
    begin
      int n;
      n = 0;
      while (!ifb.done && n < 200) begin
        tick(1);
        n++;
      end
      check("bc1_done_timeout", (n < 200), 1);
    end
    tick(3);
    check("bc1_valid_cycles", valid_b, 72);
    check("bc1_done_pulses", done_b, 1);
    check("bc1_queue_empty", expq_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_trojan_payload_leak
`default_nettype wire
